// File: rtl/xorshift_checker.sv
// Stream checker for an xorshift128 pseudo-random source: compares each received
// word against an internal reference generator and tracks errors and lock loss.
module xorshift_checker #(
  parameter int unsigned LOSS_THRESH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] seed,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic [1:0]  state,
  output logic        mismatch,
  output logic [15:0] err_count,
  output logic [31:0] word_count
);

  // Stream handshake: in_valid alone qualifies in_data; there is no ready, the
  // checker accepts one word every cycle and simply ignores words outside CHECK.

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHECK = 2'b01,
    FAIL  = 2'b10
  } state_t;

  localparam logic [31:0] X_INIT = 32'd123456789;
  localparam logic [31:0] Y_INIT = 32'd362436069;
  localparam logic [31:0] Z_INIT = 32'd521288629;
  localparam logic [31:0] W_INIT = 32'd88675123;
  localparam logic [3:0]  THRESH = 4'(LOSS_THRESH);

  state_t      state_q;
  logic [31:0] x_q, y_q, z_q, w_q;
  logic [3:0]  consec_q;

  logic [31:0] t_val;
  logic [31:0] w_next;
  logic        beat;
  logic        miss;
  logic [3:0]  consec_inc;
  logic [15:0] err_inc;

  always_comb begin
    t_val      = x_q ^ (x_q << 11);
    w_next     = w_q ^ (w_q >> 19) ^ t_val ^ (t_val >> 8);
    beat       = (state_q == CHECK) && in_valid;
    miss       = (in_data != w_q);
    consec_inc = consec_q + 4'd1;
    err_inc    = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
  end

  // start outranks in_valid: a word arriving with start is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      w_q        <= '0;
      consec_q   <= '0;
      mismatch   <= 1'b0;
      err_count  <= '0;
      word_count <= '0;
    end else if (start) begin
      state_q    <= CHECK;
      x_q        <= X_INIT;
      y_q        <= Y_INIT;
      z_q        <= Z_INIT;
      w_q        <= W_INIT ^ seed;
      consec_q   <= '0;
      mismatch   <= 1'b0;
      err_count  <= '0;
      word_count <= '0;
    end else if (beat) begin
      x_q        <= y_q;
      y_q        <= z_q;
      z_q        <= w_q;
      w_q        <= w_next;
      word_count <= word_count + 32'd1;
      mismatch   <= miss;
      if (miss) begin
        err_count <= err_inc;
        consec_q  <= consec_inc;
        if (consec_inc == THRESH) begin
          state_q <= FAIL;
        end
      end else begin
        consec_q <= '0;
      end
    end else begin
      mismatch <= 1'b0;
    end
  end

  assign state = state_q;

endmodule
